matrix_add_sub: RTL and testbench
=================================

Name: matrix_add_sub

Overview:
- Add/subtract responder on the execution engine's matrix-module handshake (enable / read-write / flag).
- The engine is the initiator. This block is the responder behind the engine's addEN / addRW / add1sub0 / matDecide outputs and drives fromASBus / addFleg.
- Holds two 4x4 operand matrices written over the 256-bit bus and computes A+B or A-B element-wise, one row per cycle.
- Returns the result on a read request, with flag handshake.

Parameters:
- DIM, 4, matrix rows/columns.
- ELEM_W, 16, element width in bits; bus width = DIM*DIM*ELEM_W = 256.

Ports:
- clk  in  1  clock
- RESET  in  1  synchronous active-high reset
- dataIn  in  256  operand bus from engine; element (r,c) at bits [(r*DIM+c)*ELEM_W +: ELEM_W]
- en  in  1  request enable from engine
- rw  in  1  1 = write operand, 0 = read result
- mat_decide  in  1  operand select on write: 0 = A, 1 = B
- add1sub0  in  1  1 = A+B, 0 = A-B; sampled when compute starts
- dataOut  out  256  result matrix, same element layout
- fleg  out  1  handshake flag to engine

Behaviour:
- One clock, clk. RESET is synchronous and active-high: on a rising edge with RESET=1, all state clears.
  - dataOut=0, fleg=0, FSM=IDLE, a_valid=b_valid=res_valid=0, row counter=0.
  - Operand registers may stay X.
  - Reset mid-compute aborts with no output.
- FSM states: IDLE, COMPUTE, DONE.
- Write (en=1, rw=1), accepted only in IDLE or DONE:
  - dataIn is captured into A (mat_decide=0) or B (mat_decide=1), and the matching valid bit is set.
  - res_valid clears; FSM goes to IDLE.
  - fleg=1 for exactly the cycle after each accepted write (ack). Back-to-back writes give fleg high every cycle.
- Write during COMPUTE: ignored, no ack.
- Read (en=1, rw=0) in IDLE:
  - If a_valid and b_valid: latch add1sub0 into op_q, row=0, go to COMPUTE, fleg=0.
  - Otherwise stay in IDLE with fleg=0. This is not an error; the engine keeps polling.
- COMPUTE:
  - Each cycle, row `row` of the working result = A_row op B_row across DIM lanes; row increments.
  - After row DIM-1 is done, dataOut loads the full working result (atomic update), res_valid=1, and the FSM goes to DONE.
  - en may drop during COMPUTE; the computation still completes.
- Latency: fleg first goes high on the 5th rising edge after the edge that samples the read request (1 start + DIM rows).
- DONE:
  - fleg = en & ~rw, registered: high while the engine keeps read asserted, low when en drops.
  - A later read with res_valid=1 gives fleg=1 one cycle later with no recompute, even if add1sub0 changed.
  - To change the operation, rewrite an operand.
- dataOut holds its last value until the next DONE entry or RESET. It does not change during IDLE or COMPUTE.
- Arithmetic (default): modulo 2^ELEM_W two's-complement wrap. 0x7FFF+0x0001 = 0x8000; 0x0000-0x0001 = 0xFFFF.
- en=0 in IDLE: no state change, fleg=0.

Optional Feature:
- MATRIX_ADD_SUB_SATURATE_EN
- Defined: elements are treated as signed, and results clamp to 0x7FFF / 0x8000 on overflow. 0x7FFF+0x0001 = 0x7FFF; 0x8000-0x0001 = 0x8000.
- Undefined: modulo wrap as above. Ports and timing are identical either way.

Decomposition:
- Shared package matrix_pkg:
  - DIM, ELEM_W, BUS_W constants.
  - elem_t typedef, row_t (DIM x elem_t) and mat_t typedefs.
  - FSM state enum (IDLE/COMPUTE/DONE).
  - Bus-slice index function. These are reused by transpose and multiply modules.
- One sub-module, row_add_sub: combinational DIM-lane add/sub on one row, with the saturation macro inside. Instantiated once and muxed by the row counter.

Test Plan:
1. Reset check: RESET=1 for 2 cycles with en=1 -> dataOut=0, fleg=0. A read with no operands then gives fleg=0 indefinitely.
2. Add:
   - Write A = all 0x0003 (mat_decide=0), then B = all 0x0005 (mat_decide=1). Each write gives a one-cycle fleg ack.
   - Read with add1sub0=1 -> fleg high on the 5th edge, dataOut = all 0x0008.
3. Subtract wrap:
   - A elements = r*4+c, B = all 0x0001, add1sub0=0.
   - Result elements = r*4+c-1, element (0,0) = 0xFFFF; dataOut unchanged until DONE.
4. Overflow:
   - A(3,3)=0x7FFF, B(3,3)=0x0001, add.
   - Result 0x8000 without the macro, 0x7FFF with MATRIX_ADD_SUB_SATURATE_EN.
5. Protocol edges:
   - Drop en during COMPUTE -> still reaches DONE; re-read gives fleg after 1 cycle, no recompute.
   - Write during COMPUTE -> ignored, no ack.
   - New write after DONE clears res_valid; the next read recomputes (5-edge latency).
6. RESET asserted on the 2nd COMPUTE cycle -> FSM=IDLE, fleg=0, dataOut=0. A read then stays idle until both operands are rewritten.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared matrix-engine types: dimensions, element/row/matrix layouts, FSM states.
// Reused by the add/sub, transpose and multiply responders.
package matrix_pkg;

  localparam int unsigned DIM    = 4;
  localparam int unsigned ELEM_W = 16;
  localparam int unsigned BUS_W  = DIM * DIM * ELEM_W;
  localparam int unsigned ROW_W  = $clog2(DIM);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [DIM-1:0]   row_t;
  // Packed so that element (r,c) lands at bits [(r*DIM+c)*ELEM_W +: ELEM_W] of the bus.
  typedef row_t [DIM-1:0]    mat_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  function automatic int unsigned elemLsb(input int unsigned r, input int unsigned c);
    return (r * DIM + c) * ELEM_W;
  endfunction

endpackage

// File: rtl/row_add_sub.sv
// Combinational DIM-lane add/subtract of one matrix row.
// MATRIX_ADD_SUB_SATURATE_EN selects signed saturation instead of modulo wrap.
module row_add_sub
  import matrix_pkg::*;
(
  input  row_t aRow,
  input  row_t bRow,
  input  logic add1sub0,
  output row_t resRow
);

`ifdef MATRIX_ADD_SUB_SATURATE_EN
  logic [ELEM_W:0] wide;

  always_comb begin
    resRow = '0;
    wide   = '0;
    for (int unsigned lane = 0; lane < DIM; lane++) begin
      // One guard bit of sign extension exposes signed overflow as a sign mismatch.
      if (add1sub0)
        wide = {aRow[lane][ELEM_W-1], aRow[lane]} + {bRow[lane][ELEM_W-1], bRow[lane]};
      else
        wide = {aRow[lane][ELEM_W-1], aRow[lane]} - {bRow[lane][ELEM_W-1], bRow[lane]};
      if (wide[ELEM_W] != wide[ELEM_W-1])
        resRow[lane] = wide[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
      else
        resRow[lane] = wide[ELEM_W-1:0];
    end
  end
`else
  always_comb begin
    resRow = '0;
    for (int unsigned lane = 0; lane < DIM; lane++) begin
      resRow[lane] = add1sub0 ? aRow[lane] + bRow[lane] : aRow[lane] - bRow[lane];
    end
  end
`endif

endmodule

// File: rtl/matrix_add_sub.sv
// Matrix add/subtract responder on the engine's enable/read-write/flag handshake.
// Optional signed saturation: define MATRIX_ADD_SUB_SATURATE_EN.
module matrix_add_sub
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             RESET,
  input  logic [BUS_W-1:0] dataIn,
  input  logic             en,
  input  logic             rw,
  input  logic             mat_decide,
  input  logic             add1sub0,
  output logic [BUS_W-1:0] dataOut,
  output logic             fleg
);

  state_t           state, stateNext;
  mat_t             aMat, bMat, work, workFull;
  logic             aValid, bValid, resValid;
  logic             opQ;
  logic [ROW_W-1:0] rowCnt;
  row_t             resRow;

  logic flegNext, loadA, loadB, clearRes, startCompute, finish;

  row_add_sub uRow (
    .aRow     (aMat[rowCnt]),
    .bRow     (bMat[rowCnt]),
    .add1sub0 (opQ),
    .resRow   (resRow)
  );

  always_ff @(posedge clk) begin
    if (RESET) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    flegNext     = 1'b0;
    loadA        = 1'b0;
    loadB        = 1'b0;
    clearRes     = 1'b0;
    startCompute = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (en && rw) begin
          loadA     = ~mat_decide;
          loadB     = mat_decide;
          clearRes  = 1'b1;
          flegNext  = 1'b1;
          stateNext = IDLE;
        end else if (en && !rw) begin
          if (state == DONE) begin
            flegNext = resValid;
          end else if (aValid && bValid) begin
            startCompute = 1'b1;
            stateNext    = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (rowCnt == ROW_W'(DIM - 1)) begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The last row goes straight from the adder into dataOut so the whole result updates at once.
  always_comb begin
    workFull         = work;
    workFull[rowCnt] = resRow;
  end

  always_ff @(posedge clk) begin
    if (loadA) aMat <= mat_t'(dataIn);
    if (loadB) bMat <= mat_t'(dataIn);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      aValid   <= 1'b0;
      bValid   <= 1'b0;
      resValid <= 1'b0;
      opQ      <= 1'b0;
      rowCnt   <= '0;
      work     <= '0;
      dataOut  <= '0;
      fleg     <= 1'b0;
    end else begin
      fleg <= flegNext;
      if (loadA)    aValid   <= 1'b1;
      if (loadB)    bValid   <= 1'b1;
      if (clearRes) resValid <= 1'b0;
      if (startCompute) begin
        opQ    <= add1sub0;
        rowCnt <= '0;
      end
      if (state == COMPUTE) begin
        work[rowCnt] <= resRow;
        rowCnt       <= rowCnt + ROW_W'(1);
      end
      if (finish) begin
        dataOut  <= workFull;
        resValid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_add_sub.sv
// Self-checking bench for matrix_add_sub: transaction-level model plus directed literal checks.
module tb_matrix_add_sub;

  logic         clk = 1'b0;
  logic         RESET, en, rw, mat_decide, add1sub0;
  logic [255:0] dataIn;
  logic [255:0] dataOut;
  logic         fleg;

  int tests = 0;
  int fails = 0;

  matrix_add_sub dut (
    .clk        (clk),
    .RESET      (RESET),
    .dataIn     (dataIn),
    .en         (en),
    .rw         (rw),
    .mat_decide (mat_decide),
    .add1sub0   (add1sub0),
    .dataOut    (dataOut),
    .fleg       (fleg)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0]  mA [16];
  logic [15:0]  mB [16];
  logic         aV, bV, done, op, expFleg, modelOn = 1'b0;
  int           busy;
  logic [255:0] expBus;

  function automatic logic [15:0] calc(input logic [15:0] a, input logic [15:0] b, input logic add);
    int sa, sb, r;
`ifdef MATRIX_ADD_SUB_SATURATE_EN
    sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
    sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
    r  = add ? sa + sb : sa - sb;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`else
    sa = int'(a);
    sb = int'(b);
    r  = add ? sa + sb : sa - sb;
`endif
    return 16'(r);
  endfunction

  always @(posedge clk) begin
    if (RESET) begin
      modelOn = 1'b1;
      aV = 1'b0; bV = 1'b0; done = 1'b0; busy = 0;
      expBus = '0; expFleg = 1'b0;
    end else if (busy > 0) begin
      expFleg = 1'b0;
      busy--;
      if (busy == 0) begin
        for (int i = 0; i < 16; i++) expBus[i*16 +: 16] = calc(mA[i], mB[i], op);
        done = 1'b1;
      end
    end else if (en && rw) begin
      for (int i = 0; i < 16; i++) begin
        if (mat_decide) mB[i] = dataIn[i*16 +: 16];
        else            mA[i] = dataIn[i*16 +: 16];
      end
      if (mat_decide) bV = 1'b1; else aV = 1'b1;
      done = 1'b0;
      expFleg = 1'b1;
    end else if (en && !rw) begin
      expFleg = 1'b0;
      if (done) expFleg = 1'b1;
      else if (aV && bV) begin
        op = add1sub0;
        busy = 4;
      end
    end else begin
      expFleg = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (modelOn) begin
      chk("model_dataOut", dataOut, expBus);
      chk("model_fleg", {255'd0, fleg}, {255'd0, expFleg});
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] b;
    for (int i = 0; i < 16; i++) b[i*16 +: 16] = v;
    return b;
  endfunction

  task automatic wr(input logic sel, input logic [255:0] d);
    en = 1'b1; rw = 1'b1; mat_decide = sel; dataIn = d;
    @(posedge clk); #1;
    chk(sel ? "ackB" : "ackA", {255'd0, fleg}, 256'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    en = 1'b0; rw = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // lat = edges after the sampling edge until fleg is seen high; -1 if bound expires
  task automatic readWait(input logic opSel, input int bound, output int lat);
    en = 1'b1; rw = 1'b0; add1sub0 = opSel;
    lat = -1;
    for (int i = 0; i <= bound; i++) begin
      @(posedge clk); #1;
      if (fleg === 1'b1) begin lat = i; break; end
    end
    @(negedge clk);
    en = 1'b0;
  endtask

  logic [255:0] seqA, ovA, ovB;
  int lat;

  initial begin
    RESET = 1'b1; en = 1'b1; rw = 1'b0; mat_decide = 1'b0; add1sub0 = 1'b0; dataIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dataOut", dataOut, '0);
    chk("rst_fleg", {255'd0, fleg}, '0);
    RESET = 1'b0;
    readWait(1'b1, 10, lat);
    chk("noOperands_lat", 256'(lat), 256'(-1));

    // add
    wr(1'b0, fill(16'h0003));
    wr(1'b1, fill(16'h0005));
    readWait(1'b1, 20, lat);
    chk("add_lat", 256'(lat), 256'd5);
    chk("add_data", dataOut, fill(16'h0008));

    // subtract with wrap
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) seqA[(r*4+c)*16 +: 16] = 16'(r*4 + c);
    wr(1'b0, seqA);
    wr(1'b1, fill(16'h0001));
    readWait(1'b0, 20, lat);
    chk("sub_lat", 256'(lat), 256'd5);
    chk("sub_e00", {240'd0, dataOut[15:0]}, 256'h0FFFF);
    chk("sub_e21", {240'd0, dataOut[9*16 +: 16]}, 256'h8);
    chk("sub_e33", {240'd0, dataOut[15*16 +: 16]}, 256'hE);

    // overflow on element (3,3)
    ovA = '0; ovA[255 -: 16] = 16'h7FFF;
    ovB = '0; ovB[255 -: 16] = 16'h0001;
    wr(1'b0, ovA);
    wr(1'b1, ovB);
    readWait(1'b1, 20, lat);
    chk("ovf_lat", 256'(lat), 256'd5);
`ifdef MATRIX_ADD_SUB_SATURATE_EN
    chk("ovf_e33", {240'd0, dataOut[255 -: 16]}, 256'h7FFF);
`else
    chk("ovf_e33", {240'd0, dataOut[255 -: 16]}, 256'h8000);
`endif
    chk("ovf_e00", {240'd0, dataOut[15:0]}, 256'h0);

    // en dropped during compute; re-read with a different op must not recompute
    wr(1'b0, fill(16'd10));
    wr(1'b1, fill(16'd4));
    en = 1'b1; rw = 1'b0; add1sub0 = 1'b0;
    @(negedge clk);
    idle(8);
    chk("dropEn_data", dataOut, fill(16'd6));
    readWait(1'b1, 10, lat);
    chk("reread_lat", 256'(lat), 256'd0);
    chk("reread_data", dataOut, fill(16'd6));

    // write during compute is ignored
    wr(1'b0, fill(16'd20));
    en = 1'b1; rw = 1'b0; add1sub0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rw = 1'b1; mat_decide = 1'b1; dataIn = fill(16'd100);
    @(posedge clk); #1;
    chk("wrInCompute_noAck", {255'd0, fleg}, '0);
    @(negedge clk);
    readWait(1'b1, 10, lat);
    chk("wrInCompute_lat", 256'(lat), 256'd3);
    chk("wrInCompute_data", dataOut, fill(16'd24));

    // new write after DONE forces recompute
    wr(1'b1, fill(16'd2));
    readWait(1'b1, 20, lat);
    chk("recompute_lat", 256'(lat), 256'd5);
    chk("recompute_data", dataOut, fill(16'd22));

    // reset on the 2nd compute cycle
    wr(1'b0, fill(16'd30));
    en = 1'b1; rw = 1'b0; add1sub0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    RESET = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RESET = 1'b0; en = 1'b0;
    chk("midRst_fleg", {255'd0, fleg}, '0);
    chk("midRst_data", dataOut, '0);
    readWait(1'b1, 10, lat);
    chk("midRst_noOps_lat", 256'(lat), 256'(-1));
    wr(1'b0, fill(16'd7));
    idle(1);
    readWait(1'b1, 10, lat);
    chk("midRst_onlyA_lat", 256'(lat), 256'(-1));
    wr(1'b1, fill(16'd1));
    readWait(1'b0, 20, lat);
    chk("midRst_final_lat", 256'(lat), 256'd5);
    chk("midRst_final_data", dataOut, fill(16'd6));

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
